// File: rtl/theremin_audio_pkg.sv
// Shared types and constants for the theremin audio output path.
// Holds the serialiser state type, the synchroniser depth and the
// default audio sample width used by i2s_dac_tx.
`timescale 1ns/1ps
package theremin_audio_pkg;

  localparam int SYNC_STAGES  = 2;
  localparam int AUD_SIG_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAD   = 2'd2
  } tx_state_t;

  // Saturating 8-bit increment, sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchroniser for one codec clock pin: STAGES metastability flops
// followed by one history flop for edge detection. rise/fall are
// combinational from the last sync flop and the history flop, so a pin
// transition becomes visible to registered logic on the third clk edge.
`timescale 1ns/1ps
module edge_sync
  import theremin_audio_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the pin through the synchroniser chain and keep one cycle of history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter towards the board codec DAC (codec is bus master).
// BCLK and DACLRCK are oversampled on clk; a mono sample is captured on
// each left-slot LRCK fall and sent MSB first in both slots, one BCLK
// after the LRCK edge, then padded with zeros to the end of the slot.
// Optional build macro I2S_DAC_TX_ERRCNT_EN adds the frame_err output,
// a saturating count of short slots and slots of the wrong length.
`timescale 1ns/1ps
module i2s_dac_tx
  import theremin_audio_pkg::*;
#(
  parameter int SIG_BITS  = AUD_SIG_BITS,
  parameter int SLOT_BITS = 32,
  parameter int fCLK      = 50_000_000,
  parameter int fBCLK     = 3_072_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SIG_BITS-1:0] in,
  input  logic                mute,
  input  logic                aud_bclk,
  input  logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                smp_strobe
`ifdef I2S_DAC_TX_ERRCNT_EN
  ,
  output logic [7:0]          frame_err
`endif
);

  localparam int CNT_W = $clog2(SIG_BITS + 1);

  if (SLOT_BITS < SIG_BITS) begin : g_chk_slot
    $error("i2s_dac_tx: SLOT_BITS must be >= SIG_BITS");
  end
  if (longint'(fCLK) < 4 * longint'(fBCLK)) begin : g_chk_clk
    $error("i2s_dac_tx: fCLK must be at least 4x the BCLK frequency");
  end

  logic bclk_rise, bclk_fall, bclk_level;
  logic lr_rise, lr_fall, lr_level;
  logic lr_edge;

  edge_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (aud_bclk),
    .rise    (bclk_rise),
    .fall    (bclk_fall),
    .level   (bclk_level)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_lr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (aud_daclrck),
    .rise    (lr_rise),
    .fall    (lr_fall),
    .level   (lr_level)
  );

  assign lr_edge = lr_rise | lr_fall;

  logic unused_sync;
  assign unused_sync = &{1'b0, bclk_rise, bclk_level, lr_level};

  tx_state_t           state;
  logic [SIG_BITS-1:0] hold;
  logic [SIG_BITS-1:0] shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SIG_BITS-1:0] cap_val;

  // Value captured at a left-slot start; also loaded straight into shreg
  // that cycle because hold only updates on the same edge.
  assign cap_val = mute ? '0 : in;

  // Capture, slot load and bit serialisation; LRCK edges win over BCLK falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hold       <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      aud_dacdat <= 1'b0;
      smp_strobe <= 1'b0;
    end else begin
      smp_strobe <= lr_fall;
      if (lr_fall) begin
        hold <= cap_val;
      end
      if (lr_edge) begin
        // From idle only a left slot may start the stream.
        if (state != S_IDLE || lr_fall) begin
          shreg   <= lr_fall ? cap_val : hold;
          bit_cnt <= CNT_W'(SIG_BITS);
          state   <= S_SHIFT;
        end
      end else if (bclk_fall) begin
        case (state)
          S_SHIFT: begin
            aud_dacdat <= shreg[SIG_BITS-1];
            shreg      <= {shreg[SIG_BITS-2:0], 1'b0};
            bit_cnt    <= bit_cnt - 1'b1;
            if (bit_cnt == CNT_W'(1)) begin
              state <= S_PAD;
            end
          end
          S_PAD: begin
            aud_dacdat <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef I2S_DAC_TX_ERRCNT_EN
  if (SLOT_BITS > 64) begin : g_chk_slot_cnt
    $error("i2s_dac_tx: SLOT_BITS too large for the 6-bit slot counter");
  end

  logic [5:0] slot_cnt;

  // Count BCLK falls inside a slot and flag slots that end early or late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt  <= '0;
      frame_err <= '0;
    end else if (lr_edge) begin
      slot_cnt <= '0;
      if (state == S_SHIFT ||
          (state == S_PAD && slot_cnt != 6'(SLOT_BITS - 1))) begin
        frame_err <= sat_inc8(frame_err);
      end
    end else if (bclk_fall && slot_cnt != 6'h3F) begin
      slot_cnt <= slot_cnt + 6'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: the slot driver acts as the codec,
// pushes the expected data bit for every BCLK rise, and a monitor pops
// and compares at each rise. Strobe timing is checked per LRCK fall.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

  localparam int HALF = 160;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] aud_in = 16'h0000;
  logic        mute = 1'b0;
  logic        aud_bclk = 1'b0;
  logic        aud_daclrck = 1'b0;
  logic        aud_dacdat;
  logic        smp_strobe;
`ifdef I2S_DAC_TX_ERRCNT_EN
  logic [7:0]  frame_err;
`endif

  i2s_dac_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in          (aud_in),
    .mute        (mute),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat),
    .smp_strobe  (smp_strobe)
`ifdef I2S_DAC_TX_ERRCNT_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    logic exp;
    int   slot;
    int   rise;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_left = 0;
  int   n_strobe = 0;
  int   slot_id = 0;

  // reference model state
  logic        m_active = 1'b0;
  logic        m_out = 1'b0;
  logic [15:0] m_hold = 16'h0000;
  logic [15:0] m_sh = 16'h0000;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One LRCK half-frame of nb BCLK periods; optional reset after rise rst_at.
  task automatic run_slot(input logic lr, input int nb, input logic [15:0] v,
                          input logic m, input int rst_at);
    slot_id++;
    aud_in = v;
    mute = m;
    aud_daclrck = lr;
    if (lr == 1'b0) begin
      m_active = 1'b1;
      m_hold = m ? 16'h0000 : v;
      n_left++;
    end
    if (m_active) begin
      m_sh = m_hold;
      m_cnt = 16;
    end
    for (int k = 1; k <= nb; k++) begin
      q.push_back('{exp: m_out, slot: slot_id, rise: k});
      #HALF aud_bclk = 1'b1;
      if (k == rst_at) begin
        #20 reset_n = 1'b0;
        #1;
        chk("dacdat_in_reset", {15'd0, aud_dacdat}, 16'd0);
        chk("strobe_in_reset", {15'd0, smp_strobe}, 16'd0);
        #99 reset_n = 1'b1;
        m_active = 1'b0;
        m_out = 1'b0;
        m_cnt = 0;
        #(HALF - 120) aud_bclk = 1'b0;
      end else begin
        #HALF aud_bclk = 1'b0;
      end
      if (k < nb && m_active) begin
        if (m_cnt > 0) begin
          m_out = m_sh[15];
          m_sh = {m_sh[14:0], 1'b0};
          m_cnt--;
        end else begin
          m_out = 1'b0;
        end
      end
    end
  endtask

  // Monitor: the codec samples data on each BCLK rise.
  initial begin
    exp_t e;
    forever begin
      @(posedge aud_bclk);
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL dacdat_no_expect: got %b want none", aud_dacdat);
      end else begin
        e = q.pop_front();
        if (aud_dacdat !== e.exp) begin
          n_fail++;
          $display("FAIL dacdat slot%0d rise%0d: got %b want %b",
                   e.slot, e.rise, aud_dacdat, e.exp);
        end
      end
    end
  end

  // Strobe must rise exactly 3 clk after each LRCK fall and last one cycle.
  initial begin
    @(posedge reset_n);
    forever begin
      @(negedge aud_daclrck);
      repeat (2) @(posedge clk);
      #1 chk("strobe_early", {15'd0, smp_strobe}, 16'd0);
      @(posedge clk);
      #1 chk("strobe_at_3clk", {15'd0, smp_strobe}, 16'd1);
      @(posedge clk);
      #1 chk("strobe_width", {15'd0, smp_strobe}, 16'd0);
    end
  end

  always @(negedge clk) begin
    if (smp_strobe === 1'b1) n_strobe++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("reset_dacdat", {15'd0, aud_dacdat}, 16'd0);
    chk("reset_strobe", {15'd0, smp_strobe}, 16'd0);
    #104 reset_n = 1'b1;

    // right slot first: ignored until the first left slot
    run_slot(1'b1, 32, 16'h7FFF, 1'b0, 0);
    // plain frame
    run_slot(1'b0, 32, 16'hA5C3, 1'b0, 0);
    run_slot(1'b1, 32, 16'hA5C3, 1'b0, 0);
    // muted frame
    run_slot(1'b0, 32, 16'h8001, 1'b1, 0);
    run_slot(1'b1, 32, 16'h8001, 1'b1, 0);
    // input changes mid-frame
    run_slot(1'b0, 32, 16'h1234, 1'b0, 0);
    run_slot(1'b1, 32, 16'hFFFF, 1'b0, 0);
    run_slot(1'b0, 32, 16'hFFFF, 1'b0, 0);
    run_slot(1'b1, 32, 16'hFFFF, 1'b0, 0);
    // short left slot, then clean frame
    run_slot(1'b0, 10, 16'h5A5A, 1'b0, 0);
    run_slot(1'b1, 32, 16'h5A5A, 1'b0, 0);
    run_slot(1'b0, 32, 16'h3C3C, 1'b0, 0);
    run_slot(1'b1, 32, 16'h3C3C, 1'b0, 0);
`ifdef I2S_DAC_TX_ERRCNT_EN
    chk("frame_err_short", {8'd0, frame_err}, 16'd1);
`endif
    // reset mid-shift, resume on next left slot
    run_slot(1'b0, 32, 16'h6B1D, 1'b0, 4);
    run_slot(1'b1, 32, 16'h6B1D, 1'b0, 0);
`ifdef I2S_DAC_TX_ERRCNT_EN
    chk("frame_err_after_reset", {8'd0, frame_err}, 16'd0);
`endif
    run_slot(1'b0, 32, 16'h6B1D, 1'b0, 0);
    run_slot(1'b1, 32, 16'h6B1D, 1'b0, 0);

    repeat (10) @(posedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    chk("strobe_count", 16'(n_strobe), 16'(n_left));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
